// File: rtl/approx_err_sweeper.sv
// Sweeps every input vector through an exact/approximate circuit pair and gathers |exact-approx| statistics.
// Latency: one vector per cycle, done 2^N_IN+2 cycles after start; no backpressure, abort/rst cancel at any time.
module approx_err_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       vec_out,
    input  logic [N_OUT-1:0]      exact_in,
    input  logic [N_OUT-1:0]      approx_in,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      max_err,
    output logic [N_IN+N_OUT-1:0] err_sum,
    output logic [N_IN:0]         viol_cnt,
    output logic [N_IN-1:0]       first_viol_vec,
    output logic                  first_viol_vld,
    output logic                  pass
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t                state_q, state_d;
    logic [N_IN-1:0]       vec_q, vec_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [N_IN-1:0]       s1_vec_q, s1_vec_d;
    logic [N_OUT-1:0]      s1_exact_q, s1_exact_d;
    logic [N_OUT-1:0]      s1_approx_q, s1_approx_d;
    logic [N_OUT-1:0]      max_err_q, max_err_d;
    logic [N_IN+N_OUT-1:0] err_sum_q, err_sum_d;
    logic [N_IN:0]         viol_cnt_q, viol_cnt_d;
    logic [N_IN-1:0]       fv_vec_q, fv_vec_d;
    logic                  fv_vld_q, fv_vld_d;
    logic                  pass_q, pass_d;
    logic [N_OUT-1:0]      err;
    logic                  err_viol;

    always_comb begin
        err      = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                : (s1_approx_q - s1_exact_q);
        err_viol = int'(err) > ET;
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        s1_vld_d    = 1'b0;
        s1_vec_d    = s1_vec_q;
        s1_exact_d  = s1_exact_q;
        s1_approx_d = s1_approx_q;
        max_err_d   = max_err_q;
        err_sum_d   = err_sum_q;
        viol_cnt_d  = viol_cnt_q;
        fv_vec_d    = fv_vec_q;
        fv_vld_d    = fv_vld_q;
        pass_d      = pass_q;

        // Stage 2 runs ahead of the FSM so a start in IDLE can override it with a clear.
        if (s1_vld_q) begin
            if (err > max_err_q) begin
                max_err_d = err;
            end
            err_sum_d = err_sum_q + {{N_IN{1'b0}}, err};
            if (err_viol) begin
                viol_cnt_d = viol_cnt_q + {{N_IN{1'b0}}, 1'b1};
                if (!fv_vld_q) begin
                    fv_vec_d = s1_vec_q;
                    fv_vld_d = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SWEEP;
                    vec_d      = '0;
                    max_err_d  = '0;
                    err_sum_d  = '0;
                    viol_cnt_d = '0;
                    fv_vec_d   = '0;
                    fv_vld_d   = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    s1_vld_d    = 1'b1;
                    s1_vec_d    = vec_q;
                    s1_exact_d  = exact_in;
                    s1_approx_d = approx_in;
                    if (vec_q == VEC_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    state_d = DONE;
                    pass_d  = int'(max_err_d) <= ET;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_vec_q    <= '0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            max_err_q   <= '0;
            err_sum_q   <= '0;
            viol_cnt_q  <= '0;
            fv_vec_q    <= '0;
            fv_vld_q    <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            s1_vld_q    <= s1_vld_d;
            s1_vec_q    <= s1_vec_d;
            s1_exact_q  <= s1_exact_d;
            s1_approx_q <= s1_approx_d;
            max_err_q   <= max_err_d;
            err_sum_q   <= err_sum_d;
            viol_cnt_q  <= viol_cnt_d;
            fv_vec_q    <= fv_vec_d;
            fv_vld_q    <= fv_vld_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == SWEEP) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign max_err        = max_err_q;
    assign err_sum        = err_sum_q;
    assign viol_cnt       = viol_cnt_q;
    assign first_viol_vec = fv_vec_q;
    assign first_viol_vld = fv_vld_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_approx_err_sweeper.sv
// Directed bench: 2-bit adder as the exact circuit, several approximate variants, abort/held-start/reset cases.
module tb_approx_err_sweeper;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [3:0] vec_out;
    logic [2:0] exact_in, approx_in;
    logic       busy, done;
    logic [2:0] max_err;
    logic [6:0] err_sum;
    logic [4:0] viol_cnt;
    logic [3:0] first_viol_vec;
    logic       first_viol_vld, pass;

    int mode;
    int checks   = 0;
    int failures = 0;

    logic [1:0] a_v, b_v;
    logic [2:0] sum_v;

    always #5 clk = ~clk;

    approx_err_sweeper #(.N_IN(4), .N_OUT(3), .ET(5)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_out(vec_out), .exact_in(exact_in), .approx_in(approx_in),
        .busy(busy), .done(done), .max_err(max_err), .err_sum(err_sum),
        .viol_cnt(viol_cnt), .first_viol_vec(first_viol_vec),
        .first_viol_vld(first_viol_vld), .pass(pass)
    );

    // mode 0: exact twin, 1: bit 2 flipped, 2: output stuck at 0, 3: err 7 at vectors 5 and 9
    always_comb begin
        a_v       = vec_out[1:0];
        b_v       = vec_out[3:2];
        sum_v     = {1'b0, a_v} + {1'b0, b_v};
        exact_in  = sum_v;
        approx_in = sum_v;
        case (mode)
            1: approx_in = sum_v ^ 3'b100;
            2: approx_in = 3'd0;
            3: if (vec_out == 4'd5 || vec_out == 4'd9) begin
                   exact_in  = 3'd7;
                   approx_in = 3'd0;
               end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle; returns at the negedge where done is seen (or after the budget).
    task automatic run_sweep(input int m, output int busy_cyc, output int done_at);
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        done_at  = -1;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_at = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_stats(input string t, input int me, input int es, input int vc,
                             input int fvv, input int fv, input int ps);
        chk({t, "_max_err"}, 32'(max_err), 32'(me));
        chk({t, "_err_sum"}, 32'(err_sum), 32'(es));
        chk({t, "_viol_cnt"}, 32'(viol_cnt), 32'(vc));
        chk({t, "_fv_vld"}, 32'(first_viol_vld), 32'(fvv));
        if (fvv != 0) chk({t, "_fv_vec"}, 32'(first_viol_vec), 32'(fv));
        chk({t, "_pass"}, 32'(pass), 32'(ps));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, da, dcnt;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vec", 32'(vec_out), 0);
        chk_stats("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        run_sweep(0, bc, da);
        chk("m0_busy_cycles", 32'(bc), 17);
        chk("m0_done_at", 32'(da), 18);
        chk_stats("m0", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("m0_done_pulse", 32'(done), 0);
        chk("m0_vec_hold", 32'(vec_out), 15);
        chk("m0_pass_hold", 32'(pass), 1);

        run_sweep(1, bc, da);
        chk("m1_done_at", 32'(da), 18);
        chk_stats("m1", 4, 64, 0, 0, 0, 1);

        run_sweep(2, bc, da);
        chk("m2_done_at", 32'(da), 18);
        chk_stats("m2", 6, 48, 1, 1, 15, 0);

        run_sweep(3, bc, da);
        chk("m3_done_at", 32'(da), 18);
        chk_stats("m3", 7, 14, 2, 1, 5, 0);

        // Abort in the 6th sweep cycle (vector 5 on the bus)
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ab_vec", 32'(vec_out), 5);
        chk("ab_busy_before", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy_after", 32'(busy), 0);
        chk("ab_pass", 32'(pass), 0);
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("ab_no_done", 32'(dcnt), 0);

        // start held high: second sweep only after returning to IDLE, stats cleared each time
        mode = 1;
        start = 1'b1;
        da = -1;
        bc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                da = i;
                break;
            end
        end
        chk("hold_done_at", 32'(da), 18);
        chk("hold_busy_cycles", 32'(bc), 17);
        chk_stats("hold1", 4, 64, 0, 0, 0, 1);
        @(negedge clk);
        chk("hold_idle_busy", 32'(busy), 0);
        chk("hold_idle_done", 32'(done), 0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", 32'(busy), 1);
        chk("hold_restart_vec", 32'(vec_out), 0);
        chk("hold_restart_clear", 32'(err_sum), 0);
        da = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                da = i;
                break;
            end
        end
        chk("hold2_done_seen", 32'(da > 0), 1);
        chk_stats("hold2", 4, 64, 0, 0, 0, 1);

        // Synchronous reset mid-sweep after a failing sweep leaves nonzero stats
        run_sweep(2, bc, da);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_done", 32'(done), 0);
        chk("rs_vec", 32'(vec_out), 0);
        chk_stats("rs", 0, 0, 0, 0, 0, 0);
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("rs_no_done", 32'(dcnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
